// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Types and constants shared by the memory-mapped UART transmitter.
//   uart_tx_state_t : transmitter FSM state encoding
//   UART_TX_ADDR    : store address the core decodes to push a byte
//   clks_per_bit()  : core clock cycles per serial bit (integer division)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // Output register sits at 16384; the UART data port is the next word.
    localparam logic [31:0] UART_TX_ADDR = 32'd16388;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with first-word fall-through read data.
//   clk_i, rstn_i      : clock, asynchronous active-low reset
//   push_i/push_data_i : write one entry (ignored while full)
//   pop_i              : drop the head entry (ignored while empty)
//   pop_data_o         : current head entry
//   full_o/empty_o     : occupancy flags, derived from count_o
//   count_o            : number of stored entries, 0..DEPTH
//
// Handshake: a push is taken on an edge where push_i=1 and full_o=0; a pop is
// taken on an edge where pop_i=1 and empty_o=0. Both may happen on the same
// edge, in which case count_o is unchanged and both pointers advance. Note a
// push while full is dropped even if a pop happens on the same edge.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i  && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Memory-mapped 8N1 UART transmitter with a byte FIFO in front of it.
//   clk_i, rstn_i        : core clock, asynchronous active-low reset
//   wr_en_i, wr_data_i   : push one byte per asserted cycle (from core store)
//   full_o, empty_o      : FIFO occupancy flags
//   count_o              : FIFO occupancy
//   busy_o               : transmitter FSM is not IDLE
//   overflow_o, clr_ovf_i: sticky push-while-full flag and its clear
//   tx_o                 : serial line, idle high, LSB first
//   dbg_state_o          : current transmitter FSM state
//
// Handshake: wr_en_i is a one-cycle request with no ready; it is accepted on
// the edge only if full_o is low, otherwise the byte is lost and overflow_o
// is set on that edge. The FSM pops the FIFO head internally.
// -----------------------------------------------------------------------------
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          wr_en_i,
    input  logic [7:0]                    wr_data_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    input  logic                          clr_ovf_i,
    output logic                          tx_o,
    output uart_tx_state_t                dbg_state_o
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int          BW           = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ_HZ / BAUD must be at least 2");
    end

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    logic [7:0] fifo_head;
    logic       fifo_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (int'(FIFO_DEPTH))
    ) u_fifo (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .push_i      (wr_en_i),
        .push_data_i (wr_data_i),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o)
    );

    // -------------------------------------------------------------------------
    // Sticky overflow flag; a new overflow beats a clear on the same edge.
    // -------------------------------------------------------------------------
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if (clr_ovf_i) begin
            overflow_d = 1'b0;
        end
        if (wr_en_i && full_o) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;

    // -------------------------------------------------------------------------
    // Transmit FSM
    // -------------------------------------------------------------------------
    uart_tx_state_t state_q;
    logic [BW-1:0]  baud_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic           tx_q;
    logic           busy_q;
    logic           baud_last;

    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    // The head is taken either from IDLE or straight out of a finishing stop
    // bit, which is what keeps back-to-back frames contiguous.
    assign fifo_pop = !empty_o &&
                      ((state_q == IDLE) || ((state_q == STOP) && baud_last));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (!empty_o) begin
                        shift_q <= fifo_head;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end

                START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end

                DATA: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            // Next bit is shift_q[1] before the shift lands.
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end

                STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (!empty_o) begin
                            shift_q <= fifo_head;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end

                default: begin
                    baud_q  <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_o        = tx_q;
    assign busy_o      = busy_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Bench for uart_tx_fifo with CLKS_PER_BIT = 4 and FIFO_DEPTH = 4. Accepted
// bytes go into exp_q; a line monitor decodes frames from tx_o and compares
// each decoded byte with the front of exp_q.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int unsigned CLK_HZ = 1000;
    localparam int unsigned BAUD_R = 250;
    localparam int unsigned DEPTH  = 4;
    localparam int          FRAME  = 40;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rstn;
    logic           wr_en;
    logic [7:0]     wr_data;
    logic           clr_ovf;
    logic           full_o;
    logic           empty_o;
    logic [2:0]     count_o;
    logic           busy_o;
    logic           overflow_o;
    logic           tx_o;
    uart_tx_state_t dbg_state;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_R),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .wr_en_i     (wr_en),
        .wr_data_i   (wr_data),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o),
        .clr_ovf_i   (clr_ovf),
        .tx_o        (tx_o),
        .dbg_state_o (dbg_state)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];

    // ---------------- line monitor / scoreboard ----------------
    int         cyc         = 0;
    int         mon_phase   = -1;
    int         frames_seen = 0;
    int         start_prev  = 0;
    int         start_last  = 0;
    logic [7:0] mon_byte    = '0;
    logic [7:0] exp_byte;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rstn) begin
            mon_phase = -1;
        end else begin
            if (mon_phase < 0 && tx_o == 1'b0) begin
                mon_phase  = 0;
                start_prev = start_last;
                start_last = cyc;
            end
            if (mon_phase >= 0) begin
                if (mon_phase == 2) begin
                    tests_run = tests_run + 1;
                    if (tx_o !== 1'b0) begin
                        tests_failed = tests_failed + 1;
                        $display("FAIL start_bit: tx_o=%b required 0 at cycle %0d", tx_o, cyc);
                    end
                end
                if (mon_phase >= 6 && mon_phase <= 34 && ((mon_phase - 6) % 4) == 0) begin
                    mon_byte[(mon_phase - 6) / 4] = tx_o;
                end
                if (mon_phase == 38) begin
                    tests_run = tests_run + 1;
                    if (tx_o !== 1'b1) begin
                        tests_failed = tests_failed + 1;
                        $display("FAIL stop_bit: tx_o=%b required 1 at cycle %0d", tx_o, cyc);
                    end
                    tests_run = tests_run + 1;
                    if (exp_q.size() == 0) begin
                        tests_failed = tests_failed + 1;
                        $display("FAIL frame_data: got unexpected frame %02h, none required", mon_byte);
                    end else begin
                        exp_byte = exp_q.pop_front();
                        if (mon_byte !== exp_byte) begin
                            tests_failed = tests_failed + 1;
                            $display("FAIL frame_data: got %02h required %02h", mon_byte, exp_byte);
                        end
                    end
                    frames_seen = frames_seen + 1;
                end
                mon_phase = (mon_phase == FRAME - 1) ? -1 : mon_phase + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; the push lands on the next rising edge.
    task automatic push_byte(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        int k;
        k = 0;
        while (frames_seen < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        ok = (frames_seen >= target);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rstn    = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        clr_ovf = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_line: tx=%b busy=%b ovf=%b required 1 0 0", tx_o, busy_o, overflow_o);
        end
        tests_run++;
        if (count_o !== 3'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_fifo: count=%0d empty=%b full=%b required 0 1 0", count_o, empty_o, full_o);
        end
        tests_run++;
        if (dbg_state !== IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: state=%0d required %0d", dbg_state, IDLE);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte;
        bit ok;
        int base;
        base = frames_seen;
        push_byte(8'hA5, 1'b1);                 // E0 has passed
        tests_run++;
        if (count_o !== 3'd1 || busy_o !== 1'b0 || tx_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_after_push: count=%0d busy=%b tx=%b required 1 0 1", count_o, busy_o, tx_o);
        end
        step(1);                                // E1
        tests_run++;
        if (tx_o !== 1'b0 || busy_o !== 1'b1 || count_o !== 3'd0) begin
            tests_failed++;
            $display("FAIL single_latency: tx=%b busy=%b count=%0d required 0 1 0", tx_o, busy_o, count_o);
        end
        step(FRAME - 1);                        // E1 + 39
        tests_run++;
        if (busy_o !== 1'b1 || tx_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_stop_busy: busy=%b tx=%b required 1 1", busy_o, tx_o);
        end
        step(1);                                // E1 + 40
        tests_run++;
        if (busy_o !== 1'b0 || tx_o !== 1'b1 || dbg_state !== IDLE) begin
            tests_failed++;
            $display("FAIL single_busy_fall: busy=%b tx=%b state=%0d required 0 1 %0d", busy_o, tx_o, dbg_state, IDLE);
        end
        wait_frames(base + 1, 20, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL single_frames: saw %0d frames required %0d", frames_seen - base, 1);
        end
        step(5);
    endtask

    task automatic test_back_to_back;
        bit ok;
        int base;
        base = frames_seen;
        push_byte(8'h00, 1'b1);
        push_byte(8'hFF, 1'b1);
        wait_frames(base + 2, 3 * FRAME, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL b2b_frames: saw %0d frames required %0d", frames_seen - base, 2);
        end
        tests_run++;
        if (start_last - start_prev !== FRAME) begin
            tests_failed++;
            $display("FAIL b2b_gap: start spacing %0d cycles required %0d", start_last - start_prev, FRAME);
        end
        step(10);
        tests_run++;
        if (busy_o !== 1'b0 || tx_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_idle: busy=%b tx=%b required 0 1", busy_o, tx_o);
        end
    endtask

    task automatic test_overflow;
        bit ok;
        int base;
        base = frames_seen;
        push_byte(8'h11, 1'b1);
        step(1);                                // first frame now in flight
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        push_byte(8'h44, 1'b1);
        push_byte(8'h55, 1'b1);
        push_byte(8'h66, 1'b0);                 // dropped: FIFO full
        tests_run++;
        if (count_o !== 3'd4 || full_o !== 1'b1 || empty_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_full: count=%0d full=%b empty=%b required 4 1 0", count_o, full_o, empty_o);
        end
        tests_run++;
        if (overflow_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set: overflow=%b required 1", overflow_o);
        end
        // Clear alone.
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        tests_run++;
        if (overflow_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: overflow=%b required 0", overflow_o);
        end
        // Clear together with a push while full: set wins.
        clr_ovf = 1'b1;
        push_byte(8'h77, 1'b0);
        clr_ovf = 1'b0;
        tests_run++;
        if (overflow_o !== 1'b1 || count_o !== 3'd4) begin
            tests_failed++;
            $display("FAIL ovf_set_wins: overflow=%b count=%0d required 1 4", overflow_o, count_o);
        end
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        wait_frames(base + 5, 6 * FRAME, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL ovf_frames: saw %0d frames required %0d", frames_seen - base, 5);
        end
        step(60);
        tests_run++;
        if (frames_seen - base !== 5 || exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL ovf_total: frames=%0d pending=%0d required 5 0", frames_seen - base, exp_q.size());
        end
    endtask

    task automatic test_simul_push_pop;
        bit ok;
        int base;
        base = frames_seen;
        push_byte(8'h3C, 1'b1);                 // E0
        push_byte(8'hC3, 1'b1);                 // E1: FSM pops 3C on the same edge
        push_byte(8'h5A, 1'b1);                 // E1 + 1
        step(FRAME - 2);                        // just past E1 + 39
        tests_run++;
        if (count_o !== 3'd2) begin
            tests_failed++;
            $display("FAIL simul_pre: count=%0d required 2", count_o);
        end
        push_byte(8'h96, 1'b1);                 // lands on E1 + 40 with the pop
        tests_run++;
        if (count_o !== 3'd2 || busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_count: count=%0d busy=%b required 2 1", count_o, busy_o);
        end
        wait_frames(base + 4, 5 * FRAME, ok);
        tests_run++;
        if (!ok || exp_q.size() !== 0) begin
            tests_failed++;
            $display("FAIL simul_frames: saw %0d frames pending=%0d required 4 0", frames_seen - base, exp_q.size());
        end
        step(10);
    endtask

    task automatic test_reset_mid_frame;
        int  base;
        bit  line_ok;
        base = frames_seen;
        push_byte(8'hE7, 1'b1);
        push_byte(8'h18, 1'b1);
        push_byte(8'h81, 1'b1);
        step(12);                               // in the middle of the first frame
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || count_o !== 3'd0 || empty_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_now: tx=%b busy=%b count=%0d empty=%b required 1 0 0 1",
                     tx_o, busy_o, count_o, empty_o);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        line_ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b1) line_ok = 1'b0;
        end
        tests_run++;
        if (!line_ok || frames_seen !== base || count_o !== 3'd0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_quiet: line_high=%b frames=%0d count=%0d busy=%b required 1 0 0 0",
                     line_ok, frames_seen - base, count_o, busy_o);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_simul_push_pop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

endmodule
